// File: rtl/pic_ack_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259-style PIC: priority resolution, INTA handshake, ISR and EOI.
// Optional macro PIC_ROTATE_EN compiles in priority rotation on EOI; without it level 0 is always highest.
module pic_ack_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] IRR,
    input  logic [7:0] IMR,
    input  logic       INTA_n,
    input  logic [4:0] vector_base,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       auto_eoi,
    input  logic       rotate_en,
    output logic       INT,
    output logic [7:0] ISR,
    output logic [7:0] clr_irr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK1  = 2'd1,
        WAIT2 = 2'd2,
        ACK2  = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] lp;
    logic [2:0] lvl;
    logic       spurious;
    logic       inta_q;
    logic       inta_seen;

    logic [7:0] pending;
    logic       pend_found;
    logic [2:0] pend_lvl;
    logic       isr_found;
    logic [2:0] isr_lvl;
    logic       int_cond;
    logic       inta_edge;
    logic       ack_edge;
    logic       eoi_hit;
    logic [2:0] eoi_lvl;
    logic [7:0] eoi_mask;
    logic [7:0] auto_mask;
    logic [7:0] set_mask;

    // Scan from the lowest-priority level upward so the last hit is the highest priority (lp+1).
    function automatic logic [3:0] find_highest(input logic [7:0] v, input logic [2:0] low);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'b0000;
        for (int i = 8; i >= 1; i--) begin
            idx = low + 3'(i);
            if (v[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    function automatic logic [2:0] rank(input logic [2:0] level, input logic [2:0] low);
        return level - low - 3'd1;
    endfunction

    always_comb begin
        pending                = IRR & ~IMR;
        {pend_found, pend_lvl} = find_highest(pending, lp);
        {isr_found, isr_lvl}   = find_highest(ISR, lp);
        int_cond  = pend_found && (!isr_found || (rank(pend_lvl, lp) < rank(isr_lvl, lp)));
        inta_edge = inta_seen && inta_q && !INTA_n;
        ack_edge  = (state == IDLE) && inta_edge;

        eoi_hit = 1'b0;
        eoi_lvl = 3'd0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                eoi_hit = ISR[eoi_level];
                eoi_lvl = eoi_level;
            end else begin
                eoi_hit = isr_found;
                eoi_lvl = isr_lvl;
            end
        end
        eoi_mask = eoi_hit ? (8'b1 << eoi_lvl) : 8'h00;

        auto_mask = 8'h00;
        if ((state == ACK2) && INTA_n && auto_eoi && !spurious)
            auto_mask = 8'b1 << lvl;

        set_mask = (ack_edge && pend_found) ? (8'b1 << pend_lvl) : 8'h00;
    end

`ifndef PIC_ROTATE_EN
    logic unused_rotate;
    assign unused_rotate = rotate_en;
`endif

    // EOI clears act on the prior ISR; a same-cycle acknowledge set is applied on top so it survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lp        <= 3'd7;
            lvl       <= 3'd0;
            spurious  <= 1'b0;
            inta_q    <= 1'b1;
            inta_seen <= 1'b0;
            INT       <= 1'b0;
            ISR       <= 8'h00;
            clr_irr   <= 8'h00;
            data_out  <= 8'h00;
            data_oe   <= 1'b0;
        end else begin
            inta_q    <= INTA_n;
            inta_seen <= 1'b1;
            ISR       <= (ISR & ~eoi_mask & ~auto_mask) | set_mask;
            clr_irr   <= set_mask;
            INT       <= (ack_edge && pend_found) ? 1'b0 : int_cond;
`ifdef PIC_ROTATE_EN
            if (eoi_hit && rotate_en)
                lp <= eoi_lvl;
`else
            lp <= 3'd7;
`endif
            case (state)
                IDLE: begin
                    if (inta_edge) begin
                        state    <= ACK1;
                        lvl      <= pend_found ? pend_lvl : 3'd7;
                        spurious <= !pend_found;
                    end
                end
                ACK1: begin
                    if (INTA_n)
                        state <= WAIT2;
                end
                WAIT2: begin
                    if (inta_edge) begin
                        state    <= ACK2;
                        data_oe  <= 1'b1;
                        data_out <= {vector_base, lvl};
                    end
                end
                ACK2: begin
                    if (INTA_n) begin
                        state    <= IDLE;
                        data_oe  <= 1'b0;
                        data_out <= 8'h00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Self-checking bench for pic_ack_sequencer: directed acknowledge scenarios followed by random
// traffic, all compared every cycle against a level-number/priority-rank reference model.
module tb_pic_ack_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] IRR, IMR;
    logic       INTA_n;
    logic [4:0] vector_base;
    logic       eoi_valid, eoi_specific;
    logic [2:0] eoi_level;
    logic       auto_eoi, rotate_en;
    logic       INT;
    logic [7:0] ISR, clr_irr, data_out;
    logic       data_oe;

    int errors = 0;
    int checks = 0;

    pic_ack_sequencer dut (
        .clk(clk), .rst_n(rst_n), .IRR(IRR), .IMR(IMR), .INTA_n(INTA_n),
        .vector_base(vector_base), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
        .eoi_level(eoi_level), .auto_eoi(auto_eoi), .rotate_en(rotate_en),
        .INT(INT), .ISR(ISR), .clr_irr(clr_irr), .data_out(data_out), .data_oe(data_oe)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 first INTA low, 2 between pulses, 3 vector phase.
    int         m_phase, m_lp, m_lvl;
    bit         m_spur, m_prev, m_seen;
    logic       m_int, m_doe;
    logic [7:0] m_isr, m_clr, m_dout;

    function automatic int top_level(logic [7:0] v, int low);
        for (int r = 0; r < 8; r++) begin
            int l;
            l = (low + 1 + r) % 8;
            if (v[l]) return l;
        end
        return -1;
    endfunction

    function automatic int rank_of(int l, int low);
        return (l - low - 1 + 16) % 8;
    endfunction

    task automatic modelReset();
        m_phase = 0; m_lp = 7; m_lvl = 0; m_spur = 0; m_prev = 1; m_seen = 0;
        m_int = 0; m_doe = 0; m_isr = 8'h00; m_clr = 8'h00; m_dout = 8'h00;
    endtask

    task automatic modelStep();
        logic [7:0] pend, new_isr, new_clr;
        int w, t, cleared;
        bit fell, new_int;
        pend    = IRR & ~IMR;
        w       = top_level(pend, m_lp);
        t       = top_level(m_isr, m_lp);
        fell    = m_seen && m_prev && !INTA_n;
        new_isr = m_isr;
        new_clr = 8'h00;
        new_int = (w >= 0) && (t < 0 || rank_of(w, m_lp) < rank_of(t, m_lp));
        if (eoi_valid) begin
            cleared = -1;
            if (eoi_specific) begin
                if (m_isr[eoi_level]) cleared = int'(eoi_level);
            end else begin
                cleared = t;
            end
            if (cleared >= 0) begin
                new_isr[cleared] = 1'b0;
`ifdef PIC_ROTATE_EN
                if (rotate_en) m_lp = cleared;
`endif
            end
        end
        case (m_phase)
            0: if (fell) begin
                m_phase = 1;
                if (w >= 0) begin
                    m_lvl = w; m_spur = 0;
                    new_isr[w] = 1'b1; new_clr[w] = 1'b1; new_int = 0;
                end else begin
                    m_lvl = 7; m_spur = 1;
                end
            end
            1: if (INTA_n) m_phase = 2;
            2: if (fell) begin
                m_phase = 3; m_doe = 1; m_dout = {vector_base, 3'(m_lvl)};
            end
            default: if (INTA_n) begin
                m_phase = 0; m_doe = 0; m_dout = 8'h00;
                if (auto_eoi && !m_spur) new_isr[m_lvl] = 1'b0;
            end
        endcase
        m_isr = new_isr; m_clr = new_clr; m_int = new_int;
        m_prev = INTA_n; m_seen = 1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("INT", {7'b0, INT}, {7'b0, m_int});
        checkOutput("ISR", ISR, m_isr);
        checkOutput("clr_irr", clr_irr, m_clr);
        checkOutput("data_out", data_out, m_dout);
        checkOutput("data_oe", {7'b0, data_oe}, {7'b0, m_doe});
    endtask

    task automatic runCycle();
        @(posedge clk);
        if (rst_n) modelStep();
        #1;
        checkAll();
    endtask

    // Two INTA pulses; reports what appeared after the first fall and during the vector phase.
    task automatic ackSequence(output logic [7:0] clr_seen, output logic [7:0] vec_seen,
                               output logic oe_seen);
        INTA_n = 0; runCycle(); clr_seen = clr_irr;
        INTA_n = 1; runCycle();
        INTA_n = 0; runCycle(); vec_seen = data_out; oe_seen = data_oe;
        INTA_n = 1; runCycle();
    endtask

    task automatic eoiPulse(input logic specific, input logic [2:0] level, input logic rot);
        eoi_valid = 1; eoi_specific = specific; eoi_level = level; rotate_en = rot;
        runCycle();
        eoi_valid = 0; rotate_en = 0;
    endtask

    task automatic applyStimulus();
        if ($urandom_range(0, 4) == 0) IRR = 8'($urandom);
        if ($urandom_range(0, 9) == 0) IMR = 8'($urandom & $urandom);
        if ($urandom_range(0, 2) == 0) INTA_n = ~INTA_n;
        eoi_valid    = ($urandom_range(0, 9) == 0);
        eoi_specific = 1'($urandom);
        eoi_level    = 3'($urandom);
        rotate_en    = 1'($urandom);
        if ($urandom_range(0, 19) == 0) auto_eoi = ~auto_eoi;
        if ($urandom_range(0, 29) == 0) vector_base = 5'($urandom);
    endtask

    logic [7:0] c, v;
    logic       oe;

    initial begin
        rst_n = 0; IRR = 0; IMR = 0; INTA_n = 1; vector_base = 5'h08;
        eoi_valid = 0; eoi_specific = 0; eoi_level = 0; auto_eoi = 0; rotate_en = 0;
        modelReset();
        #2;
        checkAll();
        #10 rst_n = 1;

        // Basic acknowledge of level 2
        IRR = 8'h04; runCycle();
        checkOutput("int_rise", {7'b0, INT}, 8'h01);
        ackSequence(c, v, oe);
        checkOutput("ack_clr", c, 8'h04);
        checkOutput("ack_isr", ISR, 8'h04);
        checkOutput("ack_vector", v, 8'h42);
        checkOutput("ack_oe", {7'b0, oe}, 8'h01);

        // Lower-priority request blocked by in-service level 2, higher one passes
        IRR = 8'h40; runCycle(); runCycle();
        checkOutput("int_blocked", {7'b0, INT}, 8'h00);
        IRR = 8'h01; runCycle();
        checkOutput("int_outranks", {7'b0, INT}, 8'h01);

        // Request withdrawn before the acknowledge edge is sampled: spurious vector
        IRR = 8'h00;
        ackSequence(c, v, oe);
        checkOutput("spur_clr", c, 8'h00);
        checkOutput("spur_vector", v, 8'h47);
        checkOutput("spur_isr", ISR, 8'h04);
        eoiPulse(0, 0, 0);
        checkOutput("eoi_clear", ISR, 8'h00);

        // Automatic EOI on level 5
        auto_eoi = 1; IRR = 8'h20; runCycle();
        ackSequence(c, v, oe);
        checkOutput("aeoi_clr", c, 8'h20);
        checkOutput("aeoi_isr", ISR, 8'h00);
        auto_eoi = 0; IRR = 8'h00; runCycle();

        // Rotation: clear level 0 with rotate, then levels 0 and 1 compete
        IRR = 8'h01; runCycle();
        ackSequence(c, v, oe);
        IRR = 8'h00;
        eoiPulse(0, 0, 1);
        IRR = 8'h03; runCycle();
        ackSequence(c, v, oe);
`ifdef PIC_ROTATE_EN
        checkOutput("rotate_winner", c, 8'h02);
`else
        checkOutput("fixed_winner", c, 8'h01);
`endif
        IRR = 8'h00;
        eoiPulse(0, 0, 0); eoiPulse(0, 0, 0);

        // Reset pulsed during WAIT2, INTA_n held low across it
        IRR = 8'h08; runCycle();
        INTA_n = 0; runCycle();
        INTA_n = 1; runCycle();
        INTA_n = 0; rst_n = 0; modelReset();
        #1;
        checkOutput("rst_INT", {7'b0, INT}, 8'h00);
        checkOutput("rst_ISR", ISR, 8'h00);
        checkOutput("rst_clr", clr_irr, 8'h00);
        checkOutput("rst_dout", data_out, 8'h00);
        checkOutput("rst_oe", {7'b0, data_oe}, 8'h00);
        #1 rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            runCycle();
            checkOutput("no_ack_clr", clr_irr, 8'h00);
        end
        checkOutput("no_ack_isr", ISR, 8'h00);
        INTA_n = 1; runCycle();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            applyStimulus();
            runCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
